// File: rtl/irq_controller.sv
// Interrupt controller: IF/IE registers, master enable with EI delay, fixed-priority vectored dispatch.
// Define IRQ_EDGE_DETECT_EN to set IF on IRQ_TRIG rising edges; otherwise IF follows the trigger level.
module irq_controller #(
    parameter int          NUM_IRQ    = 5,
    parameter logic [7:0]  VEC_BASE   = 8'h40,
    parameter int          VEC_STRIDE = 8
) (
    input  logic               CLK,
    input  logic               nRES,
    input  logic [NUM_IRQ-1:0] IRQ_TRIG,
    input  logic               REG_SEL,
    input  logic               WR,
    input  logic [7:0]         DIN,
    output logic [7:0]         DOUT,
    input  logic               IME_SET,
    input  logic               IME_CLR,
    output logic               INT_REQ,
    input  logic               INT_ACK,
    output logic [7:0]         VECTOR,
    output logic               INT_VALID,
    output logic               WAKE
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] DISPATCH = 2'd2;

    logic [1:0]         state;
    logic [NUM_IRQ-1:0] if_flags;
    logic [NUM_IRQ-1:0] ie_flags;
    logic [NUM_IRQ-1:0] if_next;
    logic [NUM_IRQ-1:0] hw_set;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [2:0]         win_idx;
    logic [7:0]         vec_next;
    logic [7:0]         vector_q;
    logic [7:0]         dout_mux;
    logic               ime;
    logic               ei_pipe;
    logic               take;
    logic               unused_din;

    assign unused_din = ^DIN;

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] trig_prev;

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            trig_prev <= '0;
        end else begin
            trig_prev <= IRQ_TRIG;
        end
    end

    assign hw_set = IRQ_TRIG & ~trig_prev;
`else
    assign hw_set = IRQ_TRIG;
`endif

    assign pending = if_flags & ie_flags;
    assign WAKE    = |pending;

    // Lowest pending index wins; clr_mask is the one-hot of the winner.
    always_comb begin
        win_idx  = '0;
        clr_mask = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_idx = 3'(i);
            end
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_mask[i] = (win_idx == 3'(i));
        end
    end

    assign vec_next = VEC_BASE + 8'(int'(win_idx) * VEC_STRIDE);
    assign take     = (state == REQ) && ime && (|pending) && INT_ACK;

    // Software write first, then dispatch clear, then hardware set so a coincident set always survives.
    always_comb begin
        if_next = if_flags;
        if (WR && !REG_SEL) begin
            if_next = DIN[NUM_IRQ-1:0];
        end
        if (take) begin
            if_next = if_next & ~clr_mask;
        end
        if_next = if_next | hw_set;
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            if_flags <= '0;
            ie_flags <= '0;
        end else begin
            if_flags <= if_next;
            if (WR && REG_SEL) begin
                ie_flags <= DIN[NUM_IRQ-1:0];
            end
        end
    end

    // EI takes effect one cycle after ei_pipe; DI (or dispatch) kills both the pipe and IME.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            ime     <= 1'b0;
            ei_pipe <= 1'b0;
        end else begin
            ei_pipe <= IME_SET && !IME_CLR;
            if (IME_CLR || take) begin
                ime <= 1'b0;
            end else if (ei_pipe) begin
                ime <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state    <= IDLE;
            vector_q <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (ime && (|pending)) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (!ime || !(|pending)) begin
                        state <= IDLE;
                    end else if (INT_ACK) begin
                        state    <= DISPATCH;
                        vector_q <= vec_next;
                    end
                end
                DISPATCH: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Unimplemented channel bits read back as 1.
    always_comb begin
        dout_mux = 8'hFF;
        dout_mux[NUM_IRQ-1:0] = REG_SEL ? ie_flags : if_flags;
    end

    assign DOUT      = dout_mux;
    assign INT_REQ   = (state == REQ);
    assign INT_VALID = (state == DISPATCH);
    assign VECTOR    = vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: dispatch vectors go through a scoreboard queue, register/status checks are direct.
module tb_irq_controller;

    logic       clk;
    logic       nres;
    logic [4:0] irq_trig;
    logic       reg_sel;
    logic       wr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       ime_set;
    logic       ime_clr;
    logic       int_req;
    logic       int_ack;
    logic [7:0] vector;
    logic       int_valid;
    logic       wake;

    int vectors_applied = 0;
    int miscompares     = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    irq_controller #(
        .NUM_IRQ    (5),
        .VEC_BASE   (8'h40),
        .VEC_STRIDE (8)
    ) dut (
        .CLK       (clk),
        .nRES      (nres),
        .IRQ_TRIG  (irq_trig),
        .REG_SEL   (reg_sel),
        .WR        (wr),
        .DIN       (din),
        .DOUT      (dout),
        .IME_SET   (ime_set),
        .IME_CLR   (ime_clr),
        .INT_REQ   (int_req),
        .INT_ACK   (int_ack),
        .VECTOR    (vector),
        .INT_VALID (int_valid),
        .WAKE      (wake)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every INT_VALID cycle must match the oldest expected vector.
    always @(negedge clk) begin
        if (nres && int_valid) begin
            vectors_applied++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_valid: VECTOR=%02h with no dispatch expected", vector);
            end else begin
                mon_exp = exp_q.pop_front();
                if (vector !== mon_exp) begin
                    miscompares++;
                    $display("[TB] FAIL dispatch_vector: got %02h, expected %02h", vector, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
        end
    endtask

    task automatic checkReg(input logic sel, input logic [7:0] expected, input string name);
        reg_sel = sel;
        #1;
        checkOutput(name, dout, expected);
    endtask

    task automatic applyStimulus(input logic [4:0] trig, input logic ack, input logic set, input logic clr);
        irq_trig = trig;
        int_ack  = ack;
        ime_set  = set;
        ime_clr  = clr;
        tick();
        int_ack  = 1'b0;
        ime_set  = 1'b0;
        ime_clr  = 1'b0;
    endtask

    task automatic writeReg(input logic sel, input logic [7:0] data);
        reg_sel = sel;
        din     = data;
        wr      = 1'b1;
        tick();
        wr      = 1'b0;
        din     = 8'h00;
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (!int_req && n < 8) begin
            tick();
            n++;
        end
        vectors_applied++;
        if (!int_req) begin
            miscompares++;
            $display("[TB] FAIL %s: INT_REQ got 0, expected 1 within 8 cycles", name);
        end
    endtask

    initial begin
        nres     = 1'b0;
        irq_trig = '0;
        reg_sel  = 1'b0;
        wr       = 1'b0;
        din      = 8'h00;
        ime_set  = 1'b0;
        ime_clr  = 1'b0;
        int_ack  = 1'b0;
        #1;
        checkReg(1'b0, 8'hE0, "reset_if");
        checkReg(1'b1, 8'hE0, "reset_ie");
        checkOutput("reset_int_req", {7'b0, int_req}, 8'h00);
        checkOutput("reset_int_valid", {7'b0, int_valid}, 8'h00);
        checkOutput("reset_vector", vector, 8'h00);
        checkOutput("reset_wake", {7'b0, wake}, 8'h00);
        tick();
        tick();
        nres = 1'b1;
        tick();

        // EI delay then dispatch of channel 2
        writeReg(1'b1, 8'h1F);
        checkReg(1'b1, 8'hFF, "ie_write");
        applyStimulus(5'b00100, 1'b0, 1'b1, 1'b0);
        irq_trig = '0;
        checkOutput("ei_delay_1", {7'b0, int_req}, 8'h00);
        checkOutput("wake_ch2", {7'b0, wake}, 8'h01);
        tick();
        checkOutput("ei_delay_2", {7'b0, int_req}, 8'h00);
        tick();
        checkOutput("req_after_ei", {7'b0, int_req}, 8'h01);
        exp_q.push_back(8'h50);
        applyStimulus(5'b00000, 1'b1, 1'b0, 1'b0);
        checkOutput("req_drop_on_ack", {7'b0, int_req}, 8'h00);
        tick();
        checkOutput("valid_one_cycle", {7'b0, int_valid}, 8'h00);
        checkReg(1'b0, 8'hE0, "if2_cleared");
        checkOutput("wake_after_dispatch", {7'b0, wake}, 8'h00);

        // Priority: IF=0x18 dispatches channel 3, leaves channel 4
        writeReg(1'b0, 8'h18);
        checkReg(1'b0, 8'hF8, "if_write");
        tick();
        checkOutput("ime_cleared_by_dispatch", {7'b0, int_req}, 8'h00);
        applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);
        waitReq("req_if18");
        exp_q.push_back(8'h58);
        applyStimulus(5'b00000, 1'b1, 1'b0, 1'b0);
        tick();
        checkReg(1'b0, 8'hF0, "if_after_prio");

        // WAKE without IME
        writeReg(1'b0, 8'h00);
        writeReg(1'b1, 8'h01);
        checkOutput("wake_idle", {7'b0, wake}, 8'h00);
        applyStimulus(5'b00001, 1'b0, 1'b0, 1'b0);
        irq_trig = '0;
        tick();
        checkOutput("wake_no_ime", {7'b0, wake}, 8'h01);
        checkOutput("no_req_no_ime", {7'b0, int_req}, 8'h00);
        checkReg(1'b0, 8'hE1, "if0_set");

        // DI while requesting aborts without dispatch
        writeReg(1'b1, 8'h1F);
        writeReg(1'b0, 8'h04);
        applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);
        waitReq("req_before_di");
        applyStimulus(5'b00000, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("abort_to_idle", {7'b0, int_req}, 8'h00);
        checkReg(1'b0, 8'hE4, "if_unchanged_abort");
        checkOutput("vector_hold", vector, 8'h58);
        applyStimulus(5'b00000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("ack_ignored_idle", {7'b0, int_valid}, 8'h00);
        applyStimulus(5'b00000, 1'b0, 1'b1, 1'b1);
        tick(); tick(); tick();
        checkOutput("ei_di_clear_wins", {7'b0, int_req}, 8'h00);
        applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'b00000, 1'b0, 1'b0, 1'b1);
        tick(); tick(); tick();
        checkOutput("di_cancels_ei", {7'b0, int_req}, 8'h00);

        // New trigger on the dispatched bit in the ack cycle keeps IF set
        writeReg(1'b0, 8'h02);
        applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);
        waitReq("req_ch1");
        exp_q.push_back(8'h48);
        applyStimulus(5'b00010, 1'b1, 1'b0, 1'b0);
        irq_trig = '0;
        tick();
        checkReg(1'b0, 8'hE2, "set_wins_over_clear");

        // Reset in the middle of a dispatch
        applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);
        waitReq("req_before_reset");
        applyStimulus(5'b00000, 1'b1, 1'b0, 1'b0);
        checkOutput("dispatch_valid", {7'b0, int_valid}, 8'h01);
        checkOutput("dispatch_vector_direct", vector, 8'h48);
        nres = 1'b0;
        #1;
        checkOutput("reset_kills_valid", {7'b0, int_valid}, 8'h00);
        checkOutput("reset_kills_vector", vector, 8'h00);
        checkReg(1'b0, 8'hE0, "reset_mid_if");
        irq_trig = 5'b01000;
        tick();
        nres = 1'b1;
        tick();
        checkReg(1'b0, 8'hE8, "held_trig_after_reset");
        checkReg(1'b1, 8'hE0, "ie_after_reset");
        writeReg(1'b0, 8'h00);
`ifdef IRQ_EDGE_DETECT_EN
        checkReg(1'b0, 8'hE0, "sw_clear_held_trig");
`else
        checkReg(1'b0, 8'hE8, "sw_clear_held_trig");
`endif
        irq_trig = '0;
        writeReg(1'b0, 8'h00);
        checkReg(1'b0, 8'hE0, "sw_clear_released");

        tick();
        tick();
        vectors_applied++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL missing_dispatch: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL provide parameter NUM_IRQ, default 5, number of interrupt channels (legal 1..8).
REQ-002 SHALL provide parameter VEC_BASE, default 8'h40, vector address of channel 0.
REQ-003 SHALL provide parameter VEC_STRIDE, default 8, vector spacing in bytes (power of two, 1..32).
REQ-004 SHALL provide port CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL provide port nRES  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port IRQ_TRIG  input  NUM_IRQ  interrupt request lines from peripherals.
REQ-007 SHALL provide port REG_SEL  input  1  register select: 0=IF, 1=IE.
REQ-008 SHALL provide port WR  input  1  register write strobe, one cycle.
REQ-009 SHALL provide port DIN  input  8  write data; bits above NUM_IRQ-1 ignored.
REQ-010 SHALL provide port DOUT  output  8  read data for REG_SEL; unused high bits read 1.
REQ-011 SHALL provide port IME_SET  input  1  EI pulse.
REQ-012 SHALL provide port IME_CLR  input  1  DI pulse.
REQ-013 SHALL provide port INT_REQ  output  1  dispatch request to sequencer.
REQ-014 SHALL provide port INT_ACK  input  1  sequencer accepts dispatch, one-cycle pulse.
REQ-015 SHALL provide port VECTOR  output  8  dispatch address, valid while INT_VALID=1.
REQ-016 SHALL provide port INT_VALID  output  1  VECTOR valid, one cycle after accepted INT_ACK.
REQ-017 SHALL provide port WAKE  output  1  any enabled IRQ pending, independent of IME (HALT exit).

Function
REQ-018 IF bit n SHALL set on a rising edge of IRQ_TRIG[n] (see REQ-034); the set is registered, visible next cycle.
REQ-019 pending SHALL equal IF & IE; WAKE SHALL equal OR(pending), combinational from registers.
REQ-020 IF write SHALL load DIN[NUM_IRQ-1:0]; if a hardware set hits the same bit in the same cycle, the set SHALL win.
REQ-021 IE write SHALL load DIN[NUM_IRQ-1:0]; IE SHALL be unaffected by dispatch.
REQ-022 Priority SHALL be fixed: lowest set pending index wins.
REQ-023 IME_SET SHALL set IME two cycles after the pulse (EI delay); IME_CLR SHALL clear IME next cycle and cancel an in-flight IME_SET; both together: clear wins.
REQ-024 FSM states SHALL be IDLE, REQ, DISPATCH.
REQ-025 IDLE->REQ when IME=1 and pending!=0; INT_REQ=1 in REQ only.
REQ-026 REQ->IDLE (no dispatch) if IME clears or pending becomes 0 before INT_ACK.
REQ-027 REQ->DISPATCH on INT_ACK: winner index latched from pending at that cycle; its IF bit cleared, IME cleared, in same edge.
REQ-028 In DISPATCH, INT_VALID=1 for exactly one cycle, VECTOR=VEC_BASE+index*VEC_STRIDE (8-bit, wraps modulo 256); then IDLE.
REQ-029 VECTOR SHALL hold its last value outside DISPATCH; INT_ACK outside REQ SHALL be ignored.
REQ-030 A new edge on the dispatched bit in the ack cycle SHALL leave IF set (set wins over clear).

Reset
REQ-031 nRES low SHALL immediately force IF=0, IE=0, IME=0, EI-delay=0, trigger history=0, FSM=IDLE.
REQ-032 During reset INT_REQ=0, INT_VALID=0, VECTOR=8'h00, WAKE=0, DOUT reflects zeroed registers.
REQ-033 Reset mid-dispatch SHALL abort with no IF/IME update beyond reset values; a trigger held high at release SHALL set IF on first clock.

Configuration
REQ-034 Macro IRQ_EDGE_DETECT_EN defined: IF sets on 0->1 of IRQ_TRIG only; undefined: IF sets every cycle IRQ_TRIG is high (level mode), software clear re-sets next cycle if still high.

Verification
REQ-035 IE=0x1F, EI, IRQ_TRIG[2] rises -> INT_REQ after EI delay; INT_ACK -> INT_VALID 1 cycle, VECTOR=0x50, IF[2]=0, IME=0.
REQ-036 IF=0x18 written, IE=0x1F, IME=1 -> dispatch VECTOR=0x58, IF=0x10 afterwards.
REQ-037 IME=0, IE[0]=1, trigger bit 0 -> WAKE=1, INT_REQ stays 0.
REQ-038 In REQ, IME_CLR before INT_ACK -> returns IDLE, no INT_VALID, IF unchanged.
REQ-039 Edge on bit 1 same cycle as INT_ACK dispatching bit 1 -> VECTOR=0x48, IF[1]=1 after.
REQ-040 nRES low during DISPATCH -> INT_VALID=0, VECTOR=0x00 at once; with macro off, held-high trigger re-sets IF after software clear.
